// File: rtl/me_pkg.sv
// Shared constants and helpers for the ME basic-layer SAD engine: pixel/window geometry,
// per-partition SAD widths and the raster packing index.
package me_pkg;

    localparam int PIX_W          = 8;
    localparam int WIN            = 32;
    localparam int ROW_W          = WIN * PIX_W;
    localparam int BLK_PER_ROW    = WIN / 4;
    localparam int DEF_STRIP_ROWS = 192;
    localparam int DEF_MAX_ROW    = 127;

    localparam int SAD_W4X4   = 12;
    localparam int SAD_W4X8   = 13;
    localparam int SAD_W8X8   = 14;
    localparam int SAD_W8X16  = 15;
    localparam int SAD_W16X16 = 16;
    localparam int SAD_W16X32 = 17;
    localparam int SAD_W32X32 = 18;

    // Raster position of a partition inside the 32x32 block: left-to-right, then top-to-bottom.
    function automatic int pack_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sad4x4_pe.sv
// Combinational 4x4 SAD element: sixteen reference/current pixel pairs reduced to one 12-bit sum.
module sad4x4_pe
    import me_pkg::*;
(
    input  logic [16*PIX_W-1:0] ref_pix,
    input  logic [16*PIX_W-1:0] cur_pix,
    output logic [SAD_W4X4-1:0] sad
);

    always_comb begin
        sad = '0;
        for (int i = 0; i < 16; i++) begin
            sad = sad + SAD_W4X4'(abs_diff(ref_pix[i*PIX_W +: PIX_W], cur_pix[i*PIX_W +: PIX_W]));
        end
    end

endmodule

// File: rtl/basic_layer_search.sv
// ME basic-layer full-search SAD engine: slides a 32-row window down a reference strip and
// reports every 4x8..32x32 partition SAD of each vertical candidate against the current quadrant.
module basic_layer_search
    import me_pkg::*;
#(
    parameter int STRIP_ROWS = DEF_STRIP_ROWS,
    parameter int MAX_ROW    = DEF_MAX_ROW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ROW_W-1:0]          ref_input,
    input  logic [2*ROW_W-1:0]        current_64pixels,
    input  logic                      ref_begin_prepare,
    input  logic                      pe_begin_prepare,
    output logic [32*SAD_W4X8-1:0]    SAD4x8,
    output logic [32*SAD_W4X8-1:0]    SAD8x4,
    output logic [16*SAD_W8X8-1:0]    SAD8x8,
    output logic [8*SAD_W8X16-1:0]    SAD8x16,
    output logic [8*SAD_W8X16-1:0]    SAD16x8,
    output logic [4*SAD_W16X16-1:0]   SAD16x16,
    output logic [2*SAD_W16X32-1:0]   SAD16x32,
    output logic [2*SAD_W16X32-1:0]   SAD32x16,
    output logic [SAD_W32X32-1:0]     SAD32x32,
    output logic [4:0]                search_column_count,
    output logic [6:0]                search_row_count
);

    localparam logic [7:0] LAST_REF   = 8'(STRIP_ROWS - 1);
    localparam logic [7:0] FIRST_FULL = 8'(WIN - 1);
    localparam logic [7:0] LAST_TOP   = 8'(WIN - 1 + MAX_ROW);
    localparam logic [5:0] CUR_SAT    = 6'd63;

    logic [ROW_W-1:0] win [WIN];
    logic [ROW_W-1:0] cur [WIN];
    logic [7:0]       ref_cnt;
    logic [5:0]       cur_cnt;
    logic             sad_pending;
    logic [6:0]       pending_row;

    // Only the left 32 pixels of each current row belong to this quadrant.
    logic unused_cur_tail;
    assign unused_cur_tail = ^current_64pixels[ROW_W-1:0];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < WIN; i++) begin
                win[i] <= '0;
            end
        end else if (ref_begin_prepare) begin
            for (int i = 0; i < WIN - 1; i++) begin
                win[i] <= win[i+1];
            end
            win[WIN-1] <= ref_input;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < WIN; i++) begin
                cur[i] <= '0;
            end
            cur_cnt <= '0;
        end else if (pe_begin_prepare) begin
            if (!cur_cnt[5]) begin
                cur[cur_cnt[4:0]] <= current_64pixels[2*ROW_W-1:ROW_W];
            end
            if (cur_cnt != CUR_SAT) begin
                cur_cnt <= cur_cnt + 6'd1;
            end
        end
    end

    // The strip wrap restarts ref_cnt, so window validity follows ref_cnt rather than its contents.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ref_cnt             <= '0;
            search_column_count <= '0;
            sad_pending         <= 1'b0;
            pending_row         <= '0;
        end else begin
            sad_pending <= 1'b0;
            if (ref_begin_prepare) begin
                if (ref_cnt == LAST_REF) begin
                    ref_cnt             <= '0;
                    search_column_count <= search_column_count + 5'd1;
                end else begin
                    ref_cnt <= ref_cnt + 8'd1;
                end
                if (ref_cnt >= FIRST_FULL && ref_cnt <= LAST_TOP) begin
                    sad_pending <= 1'b1;
                    pending_row <= 7'(ref_cnt - FIRST_FULL);
                end
            end
        end
    end

    logic [SAD_W4X4-1:0] sad4 [64];

    for (genvar br = 0; br < BLK_PER_ROW; br++) begin : g_blk_row
        for (genvar bc = 0; bc < BLK_PER_ROW; bc++) begin : g_blk_col
            logic [16*PIX_W-1:0] ref_blk;
            logic [16*PIX_W-1:0] cur_blk;
            for (genvar dy = 0; dy < 4; dy++) begin : g_line
                assign ref_blk[16*PIX_W-1-4*PIX_W*dy -: 4*PIX_W] = win[4*br+dy][ROW_W-1-4*PIX_W*bc -: 4*PIX_W];
                assign cur_blk[16*PIX_W-1-4*PIX_W*dy -: 4*PIX_W] = cur[4*br+dy][ROW_W-1-4*PIX_W*bc -: 4*PIX_W];
            end
            sad4x4_pe u_pe (
                .ref_pix (ref_blk),
                .cur_pix (cur_blk),
                .sad     (sad4[br*BLK_PER_ROW+bc])
            );
        end
    end

    logic [SAD_W4X8-1:0]   s4x8   [32];
    logic [SAD_W4X8-1:0]   s8x4   [32];
    logic [SAD_W8X8-1:0]   s8x8   [16];
    logic [SAD_W8X16-1:0]  s8x16  [8];
    logic [SAD_W8X16-1:0]  s16x8  [8];
    logic [SAD_W16X16-1:0] s16x16 [4];
    logic [SAD_W16X32-1:0] s16x32 [2];
    logic [SAD_W16X32-1:0] s32x16 [2];
    logic [SAD_W32X32-1:0] s32x32;

    // Each level merges two vertically or horizontally adjacent partitions of the level below.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                s4x8[pack_idx(r, c, 8)] = SAD_W4X8'(sad4[pack_idx(2*r, c, 8)])
                                        + SAD_W4X8'(sad4[pack_idx(2*r+1, c, 8)]);
            end
        end
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 4; c++) begin
                s8x4[pack_idx(r, c, 4)] = SAD_W4X8'(sad4[pack_idx(r, 2*c, 8)])
                                        + SAD_W4X8'(sad4[pack_idx(r, 2*c+1, 8)]);
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s8x8[pack_idx(r, c, 4)] = SAD_W8X8'(s8x4[pack_idx(2*r, c, 4)])
                                        + SAD_W8X8'(s8x4[pack_idx(2*r+1, c, 4)]);
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                s8x16[pack_idx(r, c, 4)] = SAD_W8X16'(s8x8[pack_idx(2*r, c, 4)])
                                         + SAD_W8X16'(s8x8[pack_idx(2*r+1, c, 4)]);
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 2; c++) begin
                s16x8[pack_idx(r, c, 2)] = SAD_W8X16'(s8x8[pack_idx(r, 2*c, 4)])
                                         + SAD_W8X16'(s8x8[pack_idx(r, 2*c+1, 4)]);
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                s16x16[pack_idx(r, c, 2)] = SAD_W16X16'(s16x8[pack_idx(2*r, c, 2)])
                                          + SAD_W16X16'(s16x8[pack_idx(2*r+1, c, 2)]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            s16x32[i] = SAD_W16X32'(s16x16[i]) + SAD_W16X32'(s16x16[2+i]);
            s32x16[i] = SAD_W16X32'(s16x16[2*i]) + SAD_W16X32'(s16x16[2*i+1]);
        end
        s32x32 = SAD_W32X32'(s32x16[0]) + SAD_W32X32'(s32x16[1]);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            SAD4x8           <= '0;
            SAD8x4           <= '0;
            SAD8x8           <= '0;
            SAD8x16          <= '0;
            SAD16x8          <= '0;
            SAD16x16         <= '0;
            SAD16x32         <= '0;
            SAD32x16         <= '0;
            SAD32x32         <= '0;
            search_row_count <= '0;
        end else if (sad_pending) begin
            for (int k = 0; k < 32; k++) begin
                SAD4x8[k*SAD_W4X8 +: SAD_W4X8] <= s4x8[k];
                SAD8x4[k*SAD_W4X8 +: SAD_W4X8] <= s8x4[k];
            end
            for (int k = 0; k < 16; k++) begin
                SAD8x8[k*SAD_W8X8 +: SAD_W8X8] <= s8x8[k];
            end
            for (int k = 0; k < 8; k++) begin
                SAD8x16[k*SAD_W8X16 +: SAD_W8X16] <= s8x16[k];
                SAD16x8[k*SAD_W8X16 +: SAD_W8X16] <= s16x8[k];
            end
            for (int k = 0; k < 4; k++) begin
                SAD16x16[k*SAD_W16X16 +: SAD_W16X16] <= s16x16[k];
            end
            for (int k = 0; k < 2; k++) begin
                SAD16x32[k*SAD_W16X32 +: SAD_W16X32] <= s16x32[k];
                SAD32x16[k*SAD_W16X32 +: SAD_W16X32] <= s32x16[k];
            end
            SAD32x32         <= s32x32;
            search_row_count <= pending_row;
        end
    end

endmodule

// File: tb/tb_basic_layer_search.sv
// Scoreboard bench for basic_layer_search: a strip/window reference model queues expected
// output states, and a monitor applies them at their due edge and compares every cycle.
module tb_basic_layer_search;

    localparam int STRIP_ROWS = 192;
    localparam int MAX_ROW    = 127;
    localparam int K_RESET    = 0;
    localparam int K_COL      = 1;
    localparam int K_SAD      = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] ref_input = '0;
    logic [511:0] current_64pixels = '0;
    logic         ref_begin_prepare = 1'b0;
    logic         pe_begin_prepare = 1'b0;
    logic [415:0] SAD4x8, SAD8x4;
    logic [223:0] SAD8x8;
    logic [119:0] SAD8x16, SAD16x8;
    logic [63:0]  SAD16x16;
    logic [33:0]  SAD16x32, SAD32x16;
    logic [17:0]  SAD32x32;
    logic [4:0]   search_column_count;
    logic [6:0]   search_row_count;

    always #5 clk = ~clk;

    basic_layer_search dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ref_input           (ref_input),
        .current_64pixels    (current_64pixels),
        .ref_begin_prepare   (ref_begin_prepare),
        .pe_begin_prepare    (pe_begin_prepare),
        .SAD4x8              (SAD4x8),
        .SAD8x4              (SAD8x4),
        .SAD8x8              (SAD8x8),
        .SAD8x16             (SAD8x16),
        .SAD16x8             (SAD16x8),
        .SAD16x16            (SAD16x16),
        .SAD16x32            (SAD16x32),
        .SAD32x16            (SAD32x16),
        .SAD32x32            (SAD32x32),
        .search_column_count (search_column_count),
        .search_row_count    (search_row_count)
    );

    typedef struct {
        int           due;
        int           kind;
        logic [6:0]   row;
        logic [4:0]   col;
        logic [415:0] s4x8;
        logic [415:0] s8x4;
        logic [223:0] s8x8;
        logic [119:0] s8x16;
        logic [119:0] s16x8;
        logic [63:0]  s16x16;
        logic [33:0]  s16x32;
        logic [33:0]  s32x16;
        logic [17:0]  s32x32;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         held;
    exp_t         mon_it;
    bit           armed = 1'b0;
    int           n_edges = 0;
    int           total = 0;
    int           bad = 0;

    logic [255:0] strip_q[$];
    logic [255:0] mdl_cur [32];
    logic [255:0] calc_win [32];
    int           cur_beats = 0;
    int           mdl_col = 0;

    task automatic checkOutput(input string name, input logic [415:0] act, input logic [415:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s edge=%0d actual=%0h required=%0h", name, n_edges, act, req);
        end
    endtask

    function automatic int pix(input logic [255:0] r, input int x);
        return int'(r[255-8*x -: 8]);
    endfunction

    // Straight rectangle sums of |ref-cur| over each partition, packed in raster order.
    function automatic logic [415:0] sad_field(input int wd, input int ht, input int bw);
        logic [415:0] res = '0;
        for (int r = 0; r < 32 / ht; r++) begin
            for (int c = 0; c < 32 / wd; c++) begin
                int acc = 0;
                for (int y = 0; y < ht; y++) begin
                    for (int x = 0; x < wd; x++) begin
                        int a = pix(calc_win[r*ht+y], c*wd+x);
                        int b = pix(mdl_cur[r*ht+y], c*wd+x);
                        acc += (a > b) ? a - b : b - a;
                    end
                end
                res = res | (416'(acc) << ((r * (32 / wd) + c) * bw));
            end
        end
        return res;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic applyStimulus(input bit rst, input bit ref_en, input logic [255:0] ref_row,
                                 input bit pe_en, input logic [511:0] cur_row);
        exp_t         it;
        logic [415:0] tmp;
        int           top;
        @(negedge clk);
        rst_n             = rst;
        ref_begin_prepare = ref_en;
        ref_input         = ref_row;
        pe_begin_prepare  = pe_en;
        current_64pixels  = cur_row;
        it = '{default: 0};
        if (rst) begin
            strip_q.delete();
            for (int i = 0; i < 32; i++) mdl_cur[i] = '0;
            cur_beats = 0;
            mdl_col   = 0;
            it.due    = n_edges + 1;
            it.kind   = K_RESET;
            exp_q.push_back(it);
        end else begin
            if (pe_en) begin
                if (cur_beats < 32) mdl_cur[cur_beats] = cur_row[511:256];
                cur_beats++;
            end
            if (ref_en) begin
                strip_q.push_back(ref_row);
                if (strip_q.size() == STRIP_ROWS) begin
                    strip_q.delete();
                    mdl_col = (mdl_col + 1) % 32;
                    it.due  = n_edges + 1;
                    it.kind = K_COL;
                    it.col  = 5'(mdl_col);
                    exp_q.push_back(it);
                end else if (strip_q.size() >= 32 && strip_q.size() - 32 <= MAX_ROW) begin
                    top = strip_q.size() - 32;
                    for (int i = 0; i < 32; i++) calc_win[i] = strip_q[top+i];
                    it.due    = n_edges + 2;
                    it.kind   = K_SAD;
                    it.row    = 7'(top);
                    it.s4x8   = sad_field(4, 8, 13);
                    it.s8x4   = sad_field(8, 4, 13);
                    tmp = sad_field(8, 8, 14);    it.s8x8   = tmp[223:0];
                    tmp = sad_field(8, 16, 15);   it.s8x16  = tmp[119:0];
                    tmp = sad_field(16, 8, 15);   it.s16x8  = tmp[119:0];
                    tmp = sad_field(16, 16, 16);  it.s16x16 = tmp[63:0];
                    tmp = sad_field(16, 32, 17);  it.s16x32 = tmp[33:0];
                    tmp = sad_field(32, 16, 17);  it.s32x16 = tmp[33:0];
                    tmp = sad_field(32, 32, 18);  it.s32x32 = tmp[17:0];
                    exp_q.push_back(it);
                end
            end
        end
        @(posedge clk);
    endtask

    // Monitor: apply every expected state change due at this edge, then compare all outputs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            n_edges++;
            while (exp_q.size() > 0 && exp_q[0].due <= n_edges) begin
                mon_it = exp_q.pop_front();
                if (mon_it.kind == K_RESET) begin
                    held  = '{default: 0};
                    armed = 1'b1;
                end else if (mon_it.kind == K_COL) begin
                    held.col = mon_it.col;
                end else begin
                    held.row    = mon_it.row;
                    held.s4x8   = mon_it.s4x8;
                    held.s8x4   = mon_it.s8x4;
                    held.s8x8   = mon_it.s8x8;
                    held.s8x16  = mon_it.s8x16;
                    held.s16x8  = mon_it.s16x8;
                    held.s16x16 = mon_it.s16x16;
                    held.s16x32 = mon_it.s16x32;
                    held.s32x16 = mon_it.s32x16;
                    held.s32x32 = mon_it.s32x32;
                end
            end
            if (armed) begin
                checkOutput("SAD4x8", SAD4x8, held.s4x8);
                checkOutput("SAD8x4", SAD8x4, held.s8x4);
                checkOutput("SAD8x8", 416'(SAD8x8), 416'(held.s8x8));
                checkOutput("SAD8x16", 416'(SAD8x16), 416'(held.s8x16));
                checkOutput("SAD16x8", 416'(SAD16x8), 416'(held.s16x8));
                checkOutput("SAD16x16", 416'(SAD16x16), 416'(held.s16x16));
                checkOutput("SAD16x32", 416'(SAD16x32), 416'(held.s16x32));
                checkOutput("SAD32x16", 416'(SAD32x16), 416'(held.s32x16));
                checkOutput("SAD32x32", 416'(SAD32x32), 416'(held.s32x32));
                checkOutput("row_count", 416'(search_row_count), 416'(held.row));
                checkOutput("column_count", 416'(search_column_count), 416'(held.col));
            end
        end
    end

    initial begin
        logic [255:0] row;
        logic [255:0] loc_rows [32];
        logic [7:0]   p;
        int           rows_done;
        int           cyc;
        bit           re;
        bit           pe;

        $display("[TB] start");

        // Identical data; beats past 32 carry different pixels and must be discarded.
        applyStimulus(1, 0, '0, 0, '0);
        applyStimulus(1, 0, '0, 0, '0);
        for (int i = 0; i < 64; i++)
            applyStimulus(0, 0, '0, 1, (i < 32) ? {{32{8'h10}}, {32{8'hAA}}} : {64{8'hFF}});
        for (int i = 0; i < 40; i++) applyStimulus(0, 1, {32{8'h10}}, 0, '0);
        applyStimulus(0, 0, '0, 0, '0);
        applyStimulus(0, 0, '0, 0, '0);
        #2;
        checkOutput("ident SAD32x32", 416'(SAD32x32), 416'(0));
        checkOutput("ident SAD4x8", SAD4x8, 416'(0));
        checkOutput("ident row", 416'(search_row_count), 416'(8));

        // Saturated difference.
        applyStimulus(1, 0, '0, 0, '0);
        applyStimulus(1, 0, '0, 0, '0);
        for (int i = 0; i < 32; i++) applyStimulus(0, 0, '0, 1, '0);
        for (int i = 0; i < 32; i++) applyStimulus(0, 1, {32{8'hFF}}, 0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 0, '0);
        #2;
        checkOutput("sat SAD4x8[0]", 416'(SAD4x8[12:0]), 416'(8160));
        checkOutput("sat SAD8x8[0]", 416'(SAD8x8[13:0]), 416'(16320));
        checkOutput("sat SAD16x16[0]", 416'(SAD16x16[15:0]), 416'(65280));
        checkOutput("sat SAD32x32", 416'(SAD32x32), 416'(261120));

        // Localised difference on pixel (row 9, column 20) of candidate 0.
        applyStimulus(1, 0, '0, 0, '0);
        applyStimulus(1, 0, '0, 0, '0);
        for (int i = 0; i < 32; i++) begin
            loc_rows[i] = rand256();
            applyStimulus(0, 0, '0, 1, {loc_rows[i], rand256()});
        end
        for (int i = 0; i < 32; i++) begin
            row = loc_rows[i];
            if (i == 9) begin
                p = row[95:88];
                row[95:88] = (p > 8'd250) ? p - 8'd5 : p + 8'd5;
            end
            applyStimulus(0, 1, row, 0, '0);
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 0, '0);
        #2;
        checkOutput("loc SAD4x8[13]", 416'(SAD4x8[13*13 +: 13]), 416'(5));
        checkOutput("loc SAD8x8[6]", 416'(SAD8x8[6*14 +: 14]), 416'(5));
        checkOutput("loc SAD8x8[10]", 416'(SAD8x8[10*14 +: 14]), 416'(0));
        checkOutput("loc SAD16x16[1]", 416'(SAD16x16[16 +: 16]), 416'(5));
        checkOutput("loc SAD32x16[0]", 416'(SAD32x16[16:0]), 416'(5));
        checkOutput("loc SAD32x32", 416'(SAD32x32), 416'(5));

        // Random streaming over two full strips, with a 10-cycle gating window.
        applyStimulus(1, 0, '0, 0, '0);
        applyStimulus(1, 0, '0, 0, '0);
        rows_done = 0;
        cyc = 0;
        while (rows_done < 2 * STRIP_ROWS + 40 && cyc < 4000) begin
            re = ($urandom_range(0, 3) != 0) && !(cyc >= 100 && cyc < 110);
            pe = 1'($urandom_range(0, 1));
            applyStimulus(0, re, rand256(), pe, {rand256(), rand256()});
            if (re) rows_done++;
            cyc++;
        end

        // Mid-stream reset, then a fresh strip.
        applyStimulus(1, 1, rand256(), 1, {rand256(), rand256()});
        applyStimulus(1, 1, rand256(), 1, {rand256(), rand256()});
        for (int i = 0; i < 45; i++) applyStimulus(0, 1, rand256(), 1, {rand256(), rand256()});
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, '0, 0, '0);
        #2;
        checkOutput("queue drained", 416'(exp_q.size()), 416'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
